// File: rtl/uart_dev.sv
// Memory-mapped UART: 4-entry TX FIFO feeding an 8N1 transmitter, and a receiver
// with a one-byte holding register and overrun/framing error flags.
module uart_dev #(
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  uart_addr,
  input  logic [31:0] write_data_to_uart,
  input  logic        uart_write_enable,
  input  logic        uart_read_enable,
  output logic [31:0] read_data_from_uart,
  output logic        txd,
  input  logic        rxd,
  output logic        uart_irq
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [15:0] RESET_DIV = 16'(DEFAULT_DIV);

  logic [15:0] div_reg;
  logic [1:0]  irqen;

  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  logic        rx_s1, rx_s2, rx_prev;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_data;
  logic        rx_valid, overrun, frame_err;

  logic sel_data, sel_status, sel_div, sel_irqen;
  logic wr_data, rd_data, rd_status;
  logic tx_full, tx_empty, tx_busy;
  logic push, pop, tx_bit_end;
  logic rx_fall, rx_done;
  logic [15:0] div_wval;
  logic unused_bits;

  assign sel_data   = (uart_addr[3:2] == 2'd0);
  assign sel_status = (uart_addr[3:2] == 2'd1);
  assign sel_div    = (uart_addr[3:2] == 2'd2);
  assign sel_irqen  = (uart_addr[3:2] == 2'd3);

  assign wr_data   = uart_write_enable && sel_data;
  assign rd_data   = uart_read_enable && sel_data;
  assign rd_status = uart_read_enable && sel_status;

  assign tx_full  = (count == 3'd4);
  assign tx_empty = (count == 3'd0);
  assign tx_busy  = !tx_empty || (tx_state != TX_IDLE);

  // A full FIFO drops the write even when the transmitter pops in the same cycle.
  assign push       = wr_data && !tx_full;
  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
  assign pop        = !tx_empty && ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));

  assign rx_fall = rx_prev && !rx_s2;
  assign rx_done = (rx_state == RX_STOP) && (rx_cnt == rx_div - 16'd1);

  assign div_wval    = (write_data_to_uart[15:0] < 16'd2) ? 16'd2 : write_data_to_uart[15:0];
  assign unused_bits = ^{write_data_to_uart[31:16], uart_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg  <= RESET_DIV;
      irqen    <= 2'b00;
      uart_irq <= 1'b0;
    end else begin
      if (uart_write_enable && sel_div)
        div_reg <= div_wval;
      if (uart_write_enable && sel_irqen)
        irqen <= write_data_to_uart[1:0];
      uart_irq <= (irqen[0] && tx_empty && !tx_busy) || (irqen[1] && rx_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= write_data_to_uart[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // Each bit period latches the divisor so DIV writes land on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_div   <= RESET_DIV;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            txd      <= 1'b0;
            tx_cnt   <= 16'd0;
            tx_div   <= div_reg;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= 3'd0;
            tx_cnt   <= 16'd0;
            tx_div   <= div_reg;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= 16'd0;
            tx_div <= div_reg;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= 16'd0;
            if (pop) begin
              tx_shift <= fifo_mem[rd_ptr];
              txd      <= 1'b0;
              tx_div   <= div_reg;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= RESET_DIV;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= 16'd0;
            rx_div   <= div_reg;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Half-bit check: a line already back high was a glitch.
          if (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1) begin
            rx_cnt <= 16'd0;
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= 3'd0;
              rx_div   <= div_reg;
              rx_state <= RX_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_div - 16'd1) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= 16'd0;
            rx_div   <= div_reg;
            if (rx_bit == 3'd7)
              rx_state <= RX_STOP;
            else
              rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_done) begin
            rx_cnt   <= 16'd0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Newly raised flags take priority over the clear from a same-cycle read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_done && !rx_valid) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid)
        overrun <= 1'b1;
      else if (rd_status)
        overrun <= 1'b0;
      if (rx_done && !rx_s2)
        frame_err <= 1'b1;
      else if (rd_status)
        frame_err <= 1'b0;
    end
  end

  always_comb begin
    read_data_from_uart = 32'd0;
    if (uart_read_enable) begin
      case (uart_addr[3:2])
        2'd0:    read_data_from_uart = {24'd0, rx_data};
        2'd1:    read_data_from_uart = {26'd0, frame_err, overrun, rx_valid, tx_busy, tx_empty, tx_full};
        2'd2:    read_data_from_uart = {16'd0, div_reg};
        default: read_data_from_uart = {30'd0, irqen};
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dev.sv
// Bench for uart_dev: a queue-based model predicts the serial line and TX status
// every cycle; directed register and receive checks use hand-computed values.
`timescale 1ns/1ps
module tb_uart_dev;

  localparam int DEFAULT_DIV = 434;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  uart_addr;
  logic [31:0] write_data_to_uart;
  logic        uart_write_enable;
  logic        uart_read_enable;
  logic [31:0] read_data_from_uart;
  logic        txd;
  logic        rxd;
  logic        uart_irq;
  logic        loop_en;
  logic        rxd_drv;

  int num_checks = 0;
  int num_fails  = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  uart_dev #(.DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .uart_addr           (uart_addr),
    .write_data_to_uart  (write_data_to_uart),
    .uart_write_enable   (uart_write_enable),
    .uart_read_enable    (uart_read_enable),
    .read_data_from_uart (read_data_from_uart),
    .txd                 (txd),
    .rxd                 (rxd),
    .uart_irq            (uart_irq)
  );

  always #5 clk = ~clk;

  // Line model: bytes wait in a queue of at most four; when the line has nothing
  // scheduled beyond the current cycle, the next byte expands into 10*DIV line values.
  logic [7:0] tx_q [$];
  logic       line_q [$];
  logic       exp_txd = 1'b1;
  logic       in_frame = 1'b0;
  int         model_div = DEFAULT_DIV;

  always @(posedge clk) begin : line_model
    logic [7:0] popped;
    logic       was_full;
    logic       bit_val;
    if (rst) begin
      tx_q.delete();
      line_q.delete();
      exp_txd   = 1'b1;
      in_frame  = 1'b0;
      model_div = DEFAULT_DIV;
    end else begin
      was_full = (tx_q.size() == 4);
      if (line_q.size() == 0 && tx_q.size() > 0) begin
        popped = tx_q.pop_front();
        for (int k = 0; k < 10; k++) begin
          if (k == 0)      bit_val = 1'b0;
          else if (k == 9) bit_val = 1'b1;
          else             bit_val = popped[k-1];
          for (int c = 0; c < model_div; c++) line_q.push_back(bit_val);
        end
      end
      if (uart_write_enable && uart_addr[3:2] == 2'd0 && !was_full)
        tx_q.push_back(write_data_to_uart[7:0]);
      if (uart_write_enable && uart_addr[3:2] == 2'd2)
        model_div = (write_data_to_uart[15:0] < 16'd2) ? 2 : int'(write_data_to_uart[15:0]);
      if (line_q.size() > 0) begin
        exp_txd  = line_q.pop_front();
        in_frame = 1'b1;
      end else begin
        exp_txd  = 1'b1;
        in_frame = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("txd_vs_model", {31'd0, txd}, {31'd0, exp_txd});
      if (uart_read_enable && uart_addr[3:2] == 2'd1)
        checkOutput("status_tx_vs_model", {29'd0, read_data_from_uart[2:0]},
                    {29'd0, (in_frame || tx_q.size() != 0), (tx_q.size() == 0), (tx_q.size() == 4)});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    uart_addr          = addr;
    write_data_to_uart = data;
    uart_write_enable  = 1'b1;
    @(posedge clk);
    #1;
    uart_write_enable  = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] addr, input logic [31:0] expected, input string name);
    uart_addr        = addr;
    uart_read_enable = 1'b1;
    #1;
    checkOutput(name, read_data_from_uart, expected);
    @(posedge clk);
    #1;
    uart_read_enable = 1'b0;
  endtask

  task automatic driveFrame(input logic [7:0] b, input logic stop_bit, input int div);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      rxd_drv = 1'b0;
      else if (k == 9) rxd_drv = stop_bit;
      else             rxd_drv = b[k-1];
      tick(div);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded its time bound");
    num_fails++;
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [9:0] a5_frame;
    a5_frame = 10'b1_1010_0101_0;

    rst = 1'b1;
    uart_addr = 4'd0;
    write_data_to_uart = 32'd0;
    uart_write_enable = 1'b0;
    uart_read_enable = 1'b0;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_txd", {31'd0, txd}, 32'd1);
    checkOutput("reset_irq", {31'd0, uart_irq}, 32'd0);
    checkOutput("reset_rdata_idle", read_data_from_uart, 32'd0);
    readReg(4'h4, 32'h02, "reset_status");
    readReg(4'h8, DEFAULT_DIV, "reset_div");
    readReg(4'hC, 32'h0, "reset_irqen");
    readReg(4'h0, 32'h0, "reset_data");

    // Single byte at DIV=4
    applyStimulus(4'h8, 32'd4);
    readReg(4'h8, 32'd4, "div_readback");
    applyStimulus(4'h0, 32'h0000_00A5);
    tick(1);
    for (int i = 0; i < 40; i++) begin
      checkOutput("tx_a5_line", {31'd0, txd}, {31'd0, a5_frame[i/4]});
      tick(1);
    end
    checkOutput("tx_a5_idle_after", {31'd0, txd}, 32'd1);
    readReg(4'h4, 32'h02, "status_after_a5");

    // Six consecutive writes: fifth fills the FIFO, sixth is dropped
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, 32'h11 * (i + 1));
    readReg(4'h4, 32'h05, "status_fifo_full");
    tick(210);
    readReg(4'h4, 32'h02, "status_fifo_drained");

    // Loopback at DIV=8
    applyStimulus(4'h8, 32'd8);
    loop_en = 1'b1;
    applyStimulus(4'h0, 32'h3C);
    tick(100);
    readReg(4'h4, 32'h0A, "status_rx_3c");
    readReg(4'h0, 32'h3C, "data_rx_3c");
    readReg(4'h4, 32'h02, "status_rx_consumed");
    readReg(4'h0, 32'h3C, "data_reread_last");
    applyStimulus(4'h0, 32'h01);
    applyStimulus(4'h0, 32'h02);
    tick(200);
    readReg(4'h0, 32'h01, "data_overrun_keeps_first");
    readReg(4'h4, 32'h12, "status_overrun_set");
    readReg(4'h4, 32'h02, "status_overrun_cleared");
    loop_en = 1'b0;

    // Two-cycle glitch is rejected
    rxd_drv = 1'b0;
    tick(2);
    rxd_drv = 1'b1;
    tick(100);
    readReg(4'h4, 32'h02, "status_after_glitch");
    readReg(4'h0, 32'h01, "data_after_glitch");

    // Frame with bad stop bit still delivers its byte
    driveFrame(8'h7E, 1'b0, 8);
    tick(20);
    readReg(4'h4, 32'h2A, "status_frame_err");
    readReg(4'h0, 32'h7E, "data_frame_err");
    readReg(4'h4, 32'h02, "status_frame_err_cleared");

    // Interrupts
    applyStimulus(4'hC, 32'h2);
    tick(2);
    checkOutput("irq_rx_none", {31'd0, uart_irq}, 32'd0);
    driveFrame(8'h55, 1'b1, 8);
    tick(20);
    checkOutput("irq_rx_valid", {31'd0, uart_irq}, 32'd1);
    readReg(4'h0, 32'h55, "data_irq_byte");
    checkOutput("irq_still_high_read_edge", {31'd0, uart_irq}, 32'd1);
    tick(1);
    checkOutput("irq_rx_cleared", {31'd0, uart_irq}, 32'd0);
    applyStimulus(4'hC, 32'h1);
    tick(1);
    checkOutput("irq_tx_idle", {31'd0, uart_irq}, 32'd1);
    readReg(4'hC, 32'h1, "irqen_readback");

    // Status writes have no effect
    applyStimulus(4'h4, 32'hFFFF_FFFF);
    readReg(4'h4, 32'h02, "status_write_ignored");

    // Reset during data bit 3 of 0x00
    applyStimulus(4'h8, 32'd4);
    applyStimulus(4'h0, 32'h00);
    tick(18);
    checkOutput("txd_data_bit3_low", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("txd_after_reset", {31'd0, txd}, 32'd1);
    readReg(4'h4, 32'h02, "status_after_reset");
    readReg(4'h8, DEFAULT_DIV, "div_after_reset");
    tick(2);
    checkOutput("irq_after_reset", {31'd0, uart_irq}, 32'd0);
    applyStimulus(4'h8, 32'd0);
    readReg(4'h8, 32'd2, "div_min_clamp");
    tick(20);
    checkOutput("txd_idle_end", {31'd0, txd}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
